event_arbiter: RTL and testbench

// - Round-robin arbiter sharing one convolution core's event port between NUM_REQ event sources.

---
 rtl/event_arbiter.sv | 119 +++++++++++
 tb/tb_event_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_arbiter.sv
// rtl/event_arbiter.sv - round-robin arbiter sharing one conv core event port between NUM_REQ sources
module event_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int COORD_BITS     = 8,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_BITS       = 16,
    localparam int SRC_BITS      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int EV_BITS       = 2 * COORD_BITS,
    localparam int WD_BITS       = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*EV_BITS-1:0] req_coord,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic                       conv_event_valid,
    output logic [EV_BITS-1:0]         conv_event_coord,
    output logic [SRC_BITS-1:0]        conv_event_src,
    input  logic                       conv_event_ready,
    input  logic                       conv_event_ack,
    output logic                       busy,
    output logic                       timeout_err,
    output logic [CNT_BITS-1:0]        event_count
);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t                state, state_nxt;
    logic [SRC_BITS-1:0]   last_grant, last_grant_nxt;
    logic [SRC_BITS-1:0]   src_q, src_nxt;
    logic [EV_BITS-1:0]    coord_q, coord_nxt;
    logic [WD_BITS-1:0]    wd_q, wd_nxt;
    logic [CNT_BITS-1:0]   cnt_q, cnt_nxt;
    logic                  terr_q, terr_nxt;
    logic [SRC_BITS-1:0]   pick;
    logic                  pick_found;

    // Scan from the farthest offset down so the nearest valid source after last_grant wins.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (req_valid[(int'(last_grant) + i) % NUM_REQ]) begin
                pick       = SRC_BITS'((int'(last_grant) + i) % NUM_REQ);
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        src_nxt        = src_q;
        coord_nxt      = coord_q;
        wd_nxt         = wd_q;
        cnt_nxt        = cnt_q;
        terr_nxt       = terr_q;
        case (state)
            IDLE: begin
                if (enable && pick_found && conv_event_ready) begin
                    state_nxt = BUSY;
                    src_nxt   = pick;
                    coord_nxt = req_coord[pick*EV_BITS +: EV_BITS];
                    wd_nxt    = '0;
                end
            end
            BUSY: begin
                // Ack takes precedence over a watchdog expiring in the same cycle.
                if (conv_event_ack) begin
                    state_nxt      = RELEASE;
                    cnt_nxt        = cnt_q + 1'b1;
                    last_grant_nxt = src_q;
                end else if (wd_q == WD_BITS'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt      = IDLE;
                    terr_nxt       = 1'b1;
                    last_grant_nxt = src_q;
                end else begin
                    wd_nxt = wd_q + 1'b1;
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= SRC_BITS'(NUM_REQ - 1);
            src_q      <= '0;
            coord_q    <= '0;
            wd_q       <= '0;
            cnt_q      <= '0;
            terr_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            src_q      <= src_nxt;
            coord_q    <= coord_nxt;
            wd_q       <= wd_nxt;
            cnt_q      <= cnt_nxt;
            terr_q     <= terr_nxt;
        end
    end

    always_comb begin
        req_ack = '0;
        if (state == RELEASE) req_ack[src_q] = 1'b1;
    end

    assign conv_event_valid = (state == BUSY);
    assign conv_event_coord = coord_q;
    assign conv_event_src   = src_q;
    assign busy             = (state != IDLE);
    assign timeout_err      = terr_q;
    assign event_count      = cnt_q;

endmodule

// File: tb/tb_event_arbiter.sv
// tb/tb_event_arbiter.sv - self-checking bench for event_arbiter
module tb_event_arbiter;
    localparam int N   = 3;
    localparam int CB  = 8;
    localparam int TO  = 64;
    localparam int CW  = 4;
    localparam int EVB = 2 * CB;
    localparam int SB  = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*EVB-1:0] req_coord = '0;
    logic [N-1:0]   req_ack;
    logic           conv_event_valid;
    logic [EVB-1:0] conv_event_coord;
    logic [SB-1:0]  conv_event_src;
    logic           conv_event_ready = 1'b0;
    logic           conv_event_ack = 1'b0;
    logic           busy;
    logic           timeout_err;
    logic [CW-1:0]  event_count;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    event_arbiter #(.NUM_REQ(N), .COORD_BITS(CB), .TIMEOUT_CYCLES(TO), .CNT_BITS(CW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req_valid(req_valid), .req_coord(req_coord),
        .req_ack(req_ack), .conv_event_valid(conv_event_valid), .conv_event_coord(conv_event_coord),
        .conv_event_src(conv_event_src), .conv_event_ready(conv_event_ready),
        .conv_event_ack(conv_event_ack), .busy(busy), .timeout_err(timeout_err),
        .event_count(event_count)
    );

    typedef struct {
        logic           en;
        logic [N-1:0]   req;
        logic           rdy;
        logic           ack;
        logic           valid;
        logic [SB-1:0]  src;
        logic [EVB-1:0] coord;
        logic [N-1:0]   rack;
        logic           bsy;
        logic [CW-1:0]  cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [EVB-1:0] pack(int x, int y);
        return {CB'(y), CB'(x)};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_coord(int k, logic [EVB-1:0] v);
        req_coord[k*EVB +: EVB] = v;
    endtask

    task automatic add(logic en, logic [N-1:0] req, logic rdy, logic ack, logic v, logic [SB-1:0] s,
                       logic [EVB-1:0] c, logic [N-1:0] ra, logic b, logic [CW-1:0] n);
        vec_t r;
        r.en = en; r.req = req; r.rdy = rdy; r.ack = ack; r.valid = v; r.src = s;
        r.coord = c; r.rack = ra; r.bsy = b; r.cnt = n;
        tbl.push_back(r);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; req_valid = '0; conv_event_ready = 1'b0; conv_event_ack = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_valid"}, conv_event_valid, 0);
        chk({tag, "_coord"}, conv_event_coord, 0);
        chk({tag, "_src"}, conv_event_src, 0);
        chk({tag, "_rack"}, req_ack, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_terr"}, timeout_err, 0);
        chk({tag, "_cnt"}, event_count, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [EVB-1:0] c0, c1;
        int seen, hi, acks, guard;
        c0 = pack(5, 10);
        c1 = pack(15, 20);

        // Reset values while rst_n is held low
        tick(); tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Table: enable/ready gating, ack outside BUSY, then fair alternation 0,1,0,1
        set_coord(0, c0); set_coord(1, c1); set_coord(2, pack(1, 2));
        add(0, 3'b011, 1, 0,  0, 0, '0, 3'b000, 0, 0);
        add(1, 3'b011, 0, 1,  0, 0, '0, 3'b000, 0, 0);
        add(1, 3'b011, 1, 0,  1, 0, c0, 3'b000, 1, 0);
        add(1, 3'b011, 0, 0,  1, 0, c0, 3'b000, 1, 0);
        add(1, 3'b011, 1, 1,  0, 0, c0, 3'b001, 1, 1);
        add(1, 3'b011, 1, 1,  0, 0, c0, 3'b000, 0, 1);
        add(1, 3'b011, 1, 0,  1, 1, c1, 3'b000, 1, 1);
        add(1, 3'b011, 1, 1,  0, 1, c1, 3'b010, 1, 2);
        add(1, 3'b011, 1, 0,  0, 1, c1, 3'b000, 0, 2);
        add(1, 3'b011, 1, 0,  1, 0, c0, 3'b000, 1, 2);
        add(1, 3'b011, 1, 1,  0, 0, c0, 3'b001, 1, 3);
        add(1, 3'b011, 1, 1,  0, 0, c0, 3'b000, 0, 3);
        add(1, 3'b011, 1, 0,  1, 1, c1, 3'b000, 1, 3);
        add(1, 3'b011, 1, 1,  0, 1, c1, 3'b010, 1, 4);
        add(0, 3'b011, 1, 0,  0, 1, c1, 3'b000, 0, 4);
        add(0, 3'b011, 1, 0,  0, 1, c1, 3'b000, 0, 4);
        for (int i = 0; i < tbl.size(); i++) begin
            enable = tbl[i].en; req_valid = tbl[i].req;
            conv_event_ready = tbl[i].rdy; conv_event_ack = tbl[i].ack;
            tick();
            chk($sformatf("tbl%0d_valid", i), conv_event_valid, tbl[i].valid);
            chk($sformatf("tbl%0d_src", i), conv_event_src, tbl[i].src);
            chk($sformatf("tbl%0d_coord", i), conv_event_coord, tbl[i].coord);
            chk($sformatf("tbl%0d_rack", i), req_ack, tbl[i].rack);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
            chk($sformatf("tbl%0d_cnt", i), event_count, tbl[i].cnt);
        end

        // Basic latency: grant one cycle after request, ack -> single req_ack pulse
        do_reset();
        set_coord(0, c0); enable = 1; conv_event_ready = 1; req_valid = 3'b001;
        tick();
        chk("lat_valid", conv_event_valid, 1);
        chk("lat_coord", conv_event_coord, c0);
        chk("lat_src", conv_event_src, 0);
        tick(); tick();
        chk("lat_hold", conv_event_valid, 1);
        conv_event_ack = 1;
        tick();
        conv_event_ack = 0; req_valid = 3'b000;
        chk("lat_rack", req_ack, 3'b001);
        chk("lat_cnt", event_count, 1);
        chk("lat_valid_low", conv_event_valid, 0);
        tick();
        chk("lat_rack_once", req_ack, 3'b000);

        // Ready gating
        do_reset();
        set_coord(1, c1); enable = 1; conv_event_ready = 0; req_valid = 3'b010;
        seen = 0;
        repeat (10) begin tick(); if (conv_event_valid) seen++; end
        chk("gate_no_valid", seen, 0);
        conv_event_ready = 1;
        tick();
        chk("gate_valid", conv_event_valid, 1);
        chk("gate_src", conv_event_src, 1);

        // Watchdog timeout and retry order
        do_reset();
        set_coord(0, c0); set_coord(1, c1);
        enable = 1; conv_event_ready = 1; req_valid = 3'b011;
        tick();
        chk("to_grant_src", conv_event_src, 0);
        hi = conv_event_valid ? 1 : 0; acks = 0; guard = 0;
        while (conv_event_valid && guard < 200) begin
            tick(); guard++;
            if (conv_event_valid) hi++;
            if (req_ack != 0) acks++;
        end
        chk("to_busy_cycles", hi, TO);
        chk("to_no_rack", acks, 0);
        chk("to_terr", timeout_err, 1);
        chk("to_cnt", event_count, 0);
        tick();
        chk("to_retry_valid", conv_event_valid, 1);
        chk("to_retry_src", conv_event_src, 1);
        conv_event_ack = 1;
        tick();
        conv_event_ack = 0;
        chk("to_retry_rack", req_ack, 3'b010);
        tick(); tick();
        chk("to_terr_sticky", timeout_err, 1);

        // Asynchronous reset mid-transaction
        do_reset();
        enable = 1; conv_event_ready = 1; req_valid = 3'b011;
        tick();
        conv_event_ack = 1; tick(); conv_event_ack = 0;
        tick(); tick();
        chk("ar_pre_src", conv_event_src, 1);
        #3 rst_n = 0;
        #1;
        chk_all_zero("async_rst");
        tick();
        rst_n = 1;
        tick();
        chk("ar_first_valid", conv_event_valid, 1);
        chk("ar_first_src", conv_event_src, 0);

        // Enable dropped while BUSY
        do_reset();
        enable = 1; conv_event_ready = 1; req_valid = 3'b001;
        tick();
        chk("en_grant", conv_event_valid, 1);
        enable = 0; conv_event_ack = 1;
        tick();
        conv_event_ack = 0;
        chk("en_rack", req_ack, 3'b001);
        chk("en_cnt", event_count, 1);
        req_valid = 3'b011;
        seen = 0;
        repeat (5) begin tick(); if (conv_event_valid) seen++; end
        chk("en_no_grant", seen, 0);
        enable = 1;
        tick();
        chk("en_regrant_valid", conv_event_valid, 1);
        chk("en_regrant_src", conv_event_src, 1);

        // Randomized run against a transaction-level reference model
        do_reset();
        begin
            int m_active, m_rel, m_last, m_age, m_cnt, best, bestd, d;
            logic [SB-1:0]  m_src;
            logic [EVB-1:0] m_coord;
            logic           m_terr, ack_b;
            logic [N-1:0]   pend, erack;
            m_active = -1; m_rel = -1; m_last = N - 1; m_age = 0; m_cnt = 0;
            m_src = '0; m_coord = '0; m_terr = 0; pend = '0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                erack = '0;
                if (m_rel >= 0) erack[m_rel] = 1'b1;
                chk("rnd_valid", conv_event_valid, (m_active >= 0));
                chk("rnd_busy", busy, (m_active >= 0) || (m_rel >= 0));
                chk("rnd_src", conv_event_src, m_src);
                chk("rnd_coord", conv_event_coord, m_coord);
                chk("rnd_rack", req_ack, erack);
                chk("rnd_terr", timeout_err, m_terr);
                chk("rnd_cnt", event_count, m_cnt % (1 << CW));

                for (int k = 0; k < N; k++) begin
                    if (erack[k]) pend[k] = 1'b0;
                    if (!pend[k] && $urandom_range(0, 2) == 0) begin
                        pend[k] = 1'b1;
                        set_coord(k, EVB'($urandom));
                    end else if (pend[k] && $urandom_range(0, 15) == 0) begin
                        set_coord(k, EVB'($urandom));
                    end
                end
                req_valid = pend;
                enable = ($urandom_range(0, 9) != 0);
                conv_event_ready = ($urandom_range(0, 9) < 7);
                if (m_active >= 0) ack_b = ((cyc % 600) >= 150) && ($urandom_range(0, 3) == 0);
                else ack_b = ($urandom_range(0, 7) == 0);
                conv_event_ack = ack_b;

                if (m_rel >= 0) begin
                    m_rel = -1;
                end else if (m_active >= 0) begin
                    m_age++;
                    if (ack_b) begin
                        m_cnt++; m_last = m_active; m_rel = m_active; m_active = -1;
                    end else if (m_age == TO) begin
                        m_terr = 1; m_last = m_active; m_active = -1;
                    end
                end else if (enable && conv_event_ready && (pend != 0)) begin
                    best = -1; bestd = N + 1;
                    for (int k = 0; k < N; k++) begin
                        d = (k - m_last - 1 + 2 * N) % N;
                        if (pend[k] && d < bestd) begin bestd = d; best = k; end
                    end
                    m_active = best; m_src = SB'(best);
                    m_coord = req_coord[best*EVB +: EVB]; m_age = 0;
                end
                tick();
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
